// File: rtl/pred_pkg.sv
// Shared constants, types and byte-slicing helper for the predictor/residual datapath.
package pred_pkg;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 32;
  localparam int NUM_RES   = NUM_BYTES - 1;
  localparam int RES_XOR   = 0;
  localparam int RES_SUB   = 1;

  typedef logic [BYTE_W-1:0]         byte_t;
  typedef logic [NUM_RES*BYTE_W-1:0] line_t;

  // Byte k of a line; k=0 is the most significant byte.
  function automatic byte_t byte_at(input line_t vec, input int k);
    line_t sh;
    sh = vec >> ((NUM_RES - 1 - k) * BYTE_W);
    return sh[BYTE_W-1:0];
  endfunction
endpackage

// File: rtl/resid_byte.sv
// Residual of one data byte against its prediction, plus a zero flag.
module resid_byte
  import pred_pkg::*;
#(
  parameter int RES_MODE = RES_XOR
) (
  input  logic [BYTE_W-1:0] d,
  input  logic [BYTE_W-1:0] p,
  output logic [BYTE_W-1:0] r,
  output logic              z
);

  // Subtract mode wraps modulo 256; the borrow is simply dropped.
  always_comb begin
    if (RES_MODE == RES_SUB) begin
      r = d - p;
    end else begin
      r = d ^ p;
    end
    z = (r == '0);
  end

endmodule

// File: rtl/residual_gen.sv
// Two-stage valid/ready pipeline forming per-byte residuals, zero mask and nonzero count.
module residual_gen #(
  parameter int NUM_RES  = pred_pkg::NUM_RES,
  parameter int RES_MODE = pred_pkg::RES_XOR
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [pred_pkg::BYTE_W-1:0]          root_i,
  input  logic [NUM_RES*pred_pkg::BYTE_W-1:0]  data_i,
  input  logic [NUM_RES*pred_pkg::BYTE_W-1:0]  pred_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [pred_pkg::BYTE_W-1:0]          root_o,
  output logic [NUM_RES*pred_pkg::BYTE_W-1:0]  resid_o,
  output logic [NUM_RES-1:0]                   zero_mask_o,
  output logic [$clog2(NUM_RES+1)-1:0]         nz_cnt_o,
  output logic                                 all_zero_o
);
  import pred_pkg::*;

  localparam int W     = NUM_RES * BYTE_W;
  localparam int CNT_W = $clog2(NUM_RES + 1);

  logic [W-1:0]       resid_c;
  logic [NUM_RES-1:0] zero_c;

  logic               s1_v_q, s1_v_d;
  logic [BYTE_W-1:0]  s1_root_q, s1_root_d;
  logic [W-1:0]       s1_resid_q, s1_resid_d;
  logic [NUM_RES-1:0] s1_zero_q, s1_zero_d;

  logic               s2_v_q, s2_v_d;
  logic [BYTE_W-1:0]  s2_root_q, s2_root_d;
  logic [W-1:0]       s2_resid_q, s2_resid_d;
  logic [NUM_RES-1:0] s2_zero_q, s2_zero_d;
  logic [CNT_W-1:0]   s2_nz_q, s2_nz_d;
  logic               s2_az_q, s2_az_d;

  logic [CNT_W-1:0]   zero_cnt;
  logic               s1_adv, s2_adv, in_xfer, mid_xfer;

  for (genvar k = 0; k < NUM_RES; k++) begin : g_byte
    resid_byte #(.RES_MODE(RES_MODE)) u_resid_byte (
      .d (byte_at(data_i, k)),
      .p (byte_at(pred_i, k)),
      .r (resid_c[(NUM_RES-k)*BYTE_W-1 -: BYTE_W]),
      .z (zero_c[NUM_RES-1-k])
    );
  end

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      zero_cnt = zero_cnt + CNT_W'(s1_zero_q[i]);
    end
  end

  // Ready ripples back combinationally from the encoder; there is no skid buffer.
  always_comb begin
    s2_adv   = ~s2_v_q | ready_i;
    s1_adv   = ~s1_v_q | s2_adv;
    in_xfer  = valid_i & s1_adv;
    mid_xfer = s1_v_q & s2_adv;

    s1_v_d     = s1_v_q;
    s1_root_d  = s1_root_q;
    s1_resid_d = s1_resid_q;
    s1_zero_d  = s1_zero_q;
    if (s1_adv) begin
      s1_v_d = in_xfer;
    end
    if (in_xfer) begin
      s1_root_d  = root_i;
      s1_resid_d = resid_c;
      s1_zero_d  = zero_c;
    end

    s2_v_d     = s2_v_q;
    s2_root_d  = s2_root_q;
    s2_resid_d = s2_resid_q;
    s2_zero_d  = s2_zero_q;
    s2_nz_d    = s2_nz_q;
    s2_az_d    = s2_az_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
    end
    if (mid_xfer) begin
      s2_root_d  = s1_root_q;
      s2_resid_d = s1_resid_q;
      s2_zero_d  = s1_zero_q;
      s2_nz_d    = CNT_W'(NUM_RES) - zero_cnt;
      s2_az_d    = (zero_cnt == CNT_W'(NUM_RES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_root_q  <= '0;
      s1_resid_q <= '0;
      s1_zero_q  <= '0;
      s2_v_q     <= 1'b0;
      s2_root_q  <= '0;
      s2_resid_q <= '0;
      s2_zero_q  <= '0;
      s2_nz_q    <= '0;
      s2_az_q    <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_root_q  <= s1_root_d;
      s1_resid_q <= s1_resid_d;
      s1_zero_q  <= s1_zero_d;
      s2_v_q     <= s2_v_d;
      s2_root_q  <= s2_root_d;
      s2_resid_q <= s2_resid_d;
      s2_zero_q  <= s2_zero_d;
      s2_nz_q    <= s2_nz_d;
      s2_az_q    <= s2_az_d;
    end
  end

  assign ready_o     = s1_adv;
  assign valid_o     = s2_v_q;
  assign root_o      = s2_root_q;
  assign resid_o     = s2_resid_q;
  assign zero_mask_o = s2_zero_q;
  assign nz_cnt_o    = s2_nz_q;
  assign all_zero_o  = s2_az_q;

endmodule

// File: tb/tb_residual_gen.sv
// Scoreboard bench for residual_gen: an XOR-mode and a SUB-mode instance share one input stream.
module tb_residual_gen;
  import pred_pkg::*;

  localparam int W  = 248;
  localparam int BW = 8 + W + 31 + 5 + 1;

  typedef struct packed {
    logic [7:0]   root;
    logic [W-1:0] data;
    logic [W-1:0] pred;
  } line_s;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b1;
  logic [7:0]   root_i = '0;
  logic [W-1:0] data_i = '0;
  logic [W-1:0] pred_i = '0;

  logic         x_ready, x_valid, x_az, s_ready, s_valid, s_az;
  logic [7:0]   x_root, s_root;
  logic [W-1:0] x_resid, s_resid;
  logic [30:0]  x_mask, s_mask;
  logic [4:0]   x_nz, s_nz;
  logic [BW-1:0] x_bundle, s_bundle;

  int     n_checks = 0;
  int     n_fail   = 0;
  line_s  sb[$];

  logic          cap_ready, cap_valid, cap_svalid;
  logic [BW-1:0] cap_x, cap_s;

  always #5 clk = ~clk;

  residual_gen #(.NUM_RES(31), .RES_MODE(RES_XOR)) u_xor (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(x_ready),
    .root_i(root_i), .data_i(data_i), .pred_i(pred_i),
    .valid_o(x_valid), .ready_i(ready_i), .root_o(x_root), .resid_o(x_resid),
    .zero_mask_o(x_mask), .nz_cnt_o(x_nz), .all_zero_o(x_az)
  );

  residual_gen #(.NUM_RES(31), .RES_MODE(RES_SUB)) u_sub (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(s_ready),
    .root_i(root_i), .data_i(data_i), .pred_i(pred_i),
    .valid_o(s_valid), .ready_i(ready_i), .root_o(s_root), .resid_o(s_resid),
    .zero_mask_o(s_mask), .nz_cnt_o(s_nz), .all_zero_o(s_az)
  );

  assign x_bundle = {x_root, x_resid, x_mask, x_nz, x_az};
  assign s_bundle = {s_root, s_resid, s_mask, s_nz, s_az};

  function automatic logic [BW-1:0] model(input line_s l, input int mode);
    logic [W-1:0] res;
    logic [30:0]  mask;
    logic [4:0]   nz;
    logic [7:0]   d, p, r;
    res  = '0;
    mask = '0;
    nz   = '0;
    for (int k = 0; k < 31; k++) begin
      d = l.data[(30-k)*8 +: 8];
      p = l.pred[(30-k)*8 +: 8];
      r = (mode == 1) ? 8'(d - p) : (d ^ p);
      res[(30-k)*8 +: 8] = r;
      mask[30-k] = (r == 8'h00);
      if (r != 8'h00) nz = nz + 5'd1;
    end
    return {l.root, res, mask, nz, (nz == 5'd0)};
  endfunction

  // Random line where roughly half the predictions hit exactly.
  function automatic line_s rand_line();
    line_s l;
    for (int i = 0; i < W/8; i++) begin
      l.data[i*8 +: 8] = 8'($urandom);
      l.pred[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? l.data[i*8 +: 8] : 8'($urandom);
    end
    l.root = 8'($urandom);
    return l;
  endfunction

  task automatic drive_cycle(input logic v, input line_s l, input logic rdy,
                             output logic acc, output logic fire);
    @(negedge clk);
    valid_i = v;
    root_i  = l.root;
    data_i  = l.data;
    pred_i  = l.pred;
    ready_i = rdy;
    #1;
    cap_ready  = x_ready;
    cap_valid  = x_valid;
    cap_svalid = s_valid;
    cap_x      = x_bundle;
    cap_s      = s_bundle;
    acc  = v & x_ready & ~rst;
    fire = x_valid & rdy & ~rst;
    if (acc) sb.push_back(l);
  endtask

  task automatic test_reset();
    logic acc, fire;
    line_s z;
    z = '0;
    rst = 1'b1;
    repeat (2) drive_cycle(1'b0, z, 1'b1, acc, fire);
    rst = 1'b0;
    drive_cycle(1'b0, z, 1'b1, acc, fire);
    n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_xor: got %b expected 0", cap_valid); end
    n_checks++; if (cap_svalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_sub: got %b expected 0", cap_svalid); end
    n_checks++; if (cap_x !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs_xor: got %h expected 0", cap_x); end
    n_checks++; if (cap_s !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs_sub: got %h expected 0", cap_s); end
    n_checks++; if (cap_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", cap_ready); end
  endtask

  task automatic test_equal_bytes();
    logic acc, fire, got;
    int lat;
    line_s l, e;
    l = rand_line();
    l.pred = l.data;
    l.root = 8'h5A;
    got = 1'b0;
    lat = -1;
    drive_cycle(1'b1, l, 1'b1, acc, fire);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL equal_accept: got %b expected 1", acc); end
    for (int c = 1; c <= 10 && !got; c++) begin
      drive_cycle(1'b0, l, 1'b1, acc, fire);
      if (fire) begin
        got = 1'b1;
        lat = c;
        e = sb.pop_front();
        n_checks++; if (cap_x !== {8'h5A, 248'h0, 31'h7FFF_FFFF, 5'd0, 1'b1}) begin n_fail++; $display("[TB] FAIL equal_const_xor: got %h expected all-zero residual line", cap_x); end
        n_checks++; if (cap_s !== model(e, 1)) begin n_fail++; $display("[TB] FAIL equal_sub: got %h expected %h", cap_s, model(e, 1)); end
      end
    end
    n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL equal_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_sub_borrow();
    logic acc, fire, got;
    line_s l, e;
    l = rand_line();
    l.pred = l.data;
    l.data[247:240] = 8'h03;
    l.pred[247:240] = 8'h05;
    l.root = 8'hC3;
    got = 1'b0;
    drive_cycle(1'b1, l, 1'b1, acc, fire);
    for (int c = 1; c <= 10 && !got; c++) begin
      drive_cycle(1'b0, l, 1'b1, acc, fire);
      if (fire) begin
        got = 1'b1;
        e = sb.pop_front();
        n_checks++; if (cap_s !== {8'hC3, 8'hFE, 240'h0, 31'h3FFF_FFFF, 5'd1, 1'b0}) begin n_fail++; $display("[TB] FAIL sub_const: got %h expected byte0 FE mask 3FFFFFFF nz 1", cap_s); end
        n_checks++; if (cap_x !== model(e, 0)) begin n_fail++; $display("[TB] FAIL sub_xor_model: got %h expected %h", cap_x, model(e, 0)); end
      end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL sub_timeout: got %b expected 1", got); end
  endtask

  task automatic test_back_to_back();
    logic acc, fire;
    line_s lines[8];
    line_s e;
    int sent, outs, first, last;
    sent = 0; outs = 0; first = -1; last = -1;
    for (int i = 0; i < 8; i++) lines[i] = rand_line();
    for (int c = 0; c < 40 && outs < 8; c++) begin
      drive_cycle(sent < 8, lines[(sent < 8) ? sent : 7], 1'b1, acc, fire);
      if (acc) sent++;
      if (fire) begin
        if (first < 0) first = c;
        last = c;
        outs++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_spurious: got output expected none");
        end else begin
          e = sb.pop_front();
          if (cap_x !== model(e, 0) || cap_s !== model(e, 1)) begin
            n_fail++; $display("[TB] FAIL b2b_line%0d: got %h expected %h", outs - 1, cap_x, model(e, 0));
          end
        end
      end
    end
    n_checks++; if (outs !== 8) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 8", outs); end
    n_checks++; if (last - first !== 7) begin n_fail++; $display("[TB] FAIL b2b_gap: got span %0d expected 7", last - first); end
  endtask

  task automatic test_stall();
    logic acc, fire, have_prev, full_before;
    line_s lines[3];
    line_s e;
    logic [BW-1:0] prev_x, prev_s;
    int sent, outs;
    sent = 0; outs = 0; have_prev = 1'b0;
    prev_x = '0; prev_s = '0;
    for (int i = 0; i < 3; i++) lines[i] = rand_line();
    for (int c = 0; c < 30 && outs < 3; c++) begin
      full_before = (sent == 2);
      drive_cycle(sent < 3, lines[(sent < 3) ? sent : 2], c >= 5, acc, fire);
      if (c < 2) begin
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_accept%0d: got %b expected 1", c, acc); end
      end
      if (full_before && c < 5) begin
        n_checks++; if (cap_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready_c%0d: got %b expected 0", c, cap_ready); end
      end
      if (c < 5 && cap_valid) begin
        if (have_prev) begin
          n_checks++;
          if (cap_x !== prev_x || cap_s !== prev_s) begin
            n_fail++; $display("[TB] FAIL stall_stable_c%0d: got %h expected %h", c, cap_x, prev_x);
          end
        end
        prev_x = cap_x;
        prev_s = cap_s;
        have_prev = 1'b1;
      end
      if (acc) sent++;
      if (fire) begin
        outs++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("[TB] FAIL stall_spurious: got output expected none");
        end else begin
          e = sb.pop_front();
          if (cap_x !== model(e, 0) || cap_s !== model(e, 1)) begin
            n_fail++; $display("[TB] FAIL stall_line%0d: got %h expected %h", outs - 1, cap_x, model(e, 0));
          end
        end
      end
    end
    n_checks++; if (outs !== 3 || sb.size() !== 0) begin n_fail++; $display("[TB] FAIL stall_drain: got %0d outputs %0d left expected 3 and 0", outs, sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic acc, fire, got;
    int lat;
    line_s l0, l1, z, e;
    l0 = rand_line(); l1 = rand_line(); z = '0;
    drive_cycle(1'b1, l0, 1'b0, acc, fire);
    drive_cycle(1'b1, l1, 1'b0, acc, fire);
    drive_cycle(1'b0, z, 1'b0, acc, fire);
    n_checks++; if (cap_valid !== 1'b1 || cap_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_inflight: got valid %b ready %b expected 1 0", cap_valid, cap_ready); end
    rst = 1'b1;
    sb.delete();
    drive_cycle(1'b0, z, 1'b1, acc, fire);
    rst = 1'b0;
    n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %b expected 0", cap_valid); end
    n_checks++; if (cap_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready: got %b expected 1", cap_ready); end
    n_checks++; if (cap_x !== '0 || cap_s !== '0) begin n_fail++; $display("[TB] FAIL rstmid_cleared: got %h expected 0", cap_x); end
    l0 = rand_line();
    got = 1'b0;
    lat = -1;
    drive_cycle(1'b1, l0, 1'b1, acc, fire);
    for (int c = 1; c <= 10 && !got; c++) begin
      drive_cycle(1'b0, z, 1'b1, acc, fire);
      if (fire) begin
        got = 1'b1;
        lat = c;
        e = sb.pop_front();
        n_checks++; if (cap_x !== model(e, 0) || cap_s !== model(e, 1)) begin n_fail++; $display("[TB] FAIL rstmid_fresh: got %h expected %h", cap_x, model(e, 0)); end
      end
    end
    n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL rstmid_latency: got %0d expected 2", lat); end
  endtask

  initial begin
    test_reset();
    test_equal_bytes();
    test_sub_borrow();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
